sync_fifo_flex: RTL and testbench
=================================

# sync_fifo_flex

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds a selectable read mode (standard or first-word-fall-through), non-power-of-two depth, runtime almost-empty/almost-full thresholds, synchronous flush and sticky overflow/underflow error flags. Storage is an internal register array. The block sits between any producer/consumer pair in the same clock domain.

## Interface
- DWIDTH, 16, data word width
- AWIDTH, 4, pointer width; DEPTH <= 2^AWIDTH required
- DEPTH, 16, number of entries, 2..2^AWIDTH, need not be a power of two
- FWFT, 0, read mode: 0 = standard (1-cycle registered read), 1 = first-word-fall-through
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- flush  input  1  synchronous clear of pointers and count
- push  input  1  write request
- in  input  DWIDTH  write data
- pop  input  1  read request
- ae_thr  input  AWIDTH+1  almost-empty threshold
- af_thr  input  AWIDTH+1  almost-full threshold
- err_clr  input  1  clears overflow and underflow
- out  output  DWIDTH  read data
- out_valid  output  1  out holds a valid word (meaning per mode, below)
- empty, full  output  1  num==0, num==DEPTH
- almostempty  output  1  num <= ae_thr
- almostfull  output  1  num >= af_thr
- num  output  AWIDTH+1  current occupancy, 0..DEPTH
- overflow, underflow  output  1  sticky error flags

## Operation
- Accept rules: wr_ok = push & (!full | pop); rd_ok = pop & !empty. At full, push+pop both accepted (write-through). At empty, pop is rejected and push is accepted.
- Write: on wr_ok, mem[wPtr] <= in; wPtr advances.
- Read: on rd_ok, rPtr advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0, never to DEPTH.
- Count: num +1 on wr_ok&!rd_ok; -1 on rd_ok&!wr_ok; unchanged otherwise. num never exceeds DEPTH or goes below 0.
- Standard mode (FWFT=0):
  - On rd_ok, out <= mem[rPtr] (the old contents, even when wPtr==rPtr at full).
  - out_valid <= rd_ok, a 1-cycle pulse.
  - out holds its value between reads.
- FWFT mode (FWFT=1):
  - out = mem[rPtr] when !empty, else 0 (combinational from storage).
  - out_valid = !empty.
  - pop consumes the displayed word.
- Errors:
  - overflow sets on push & full & !pop.
  - underflow sets on pop & empty.
  - Both are sticky until err_clr. If err_clr and a new error occur in the same cycle, set wins.
  - Rejected operations change no other state.
- Flush: pointers and num <= 0 and out_valid <= 0. push and pop in the same cycle are ignored. out keeps its value in standard mode. Error flags are unaffected.
- Priority: reset > flush > push/pop.
- Thresholds are compared every cycle. A change on ae_thr or af_thr takes effect combinationally.

## Timing
- Reset values: num=0, empty=1, full=0, almostempty=1, almostfull=(af_thr==0), out=0, out_valid=0, overflow=0, underflow=0, pointers=0. Memory is not reset.
- Reset assertion mid-operation clears state immediately (asynchronous). Deassertion takes effect at the next clk edge.
- All flags are combinational from num, so they update in the cycle after the accepting edge.
- Standard mode: data appears on out 1 cycle after the pop edge.
- FWFT mode: a word pushed into an empty FIFO is visible on out, with out_valid=1, in the cycle after the push edge.
- Write-to-read throughput is 1 word per cycle sustained in both modes.
- The error flag is set at the edge of the offending cycle.

## Test plan
- Fill and drain, DEPTH=16, FWFT=0:
  - Push 0x0001..0x0010 on 16 consecutive cycles -> full=1, num=16.
  - 17th push -> overflow=1, num stays 16.
  - Pop 16 times -> out=0x0001..0x0010, each 1 cycle after its pop, with out_valid pulses.
  - Then empty=1; one more pop -> underflow=1.
- Non-power-of-two wrap, DEPTH=12, AWIDTH=4:
  - Push 8, pop 8, push 12 -> full=1, wPtr wrapped through 11->0.
  - Drain -> data order preserved, num 12->0.
- FWFT latency:
  - Push 0xA5A5 into empty FIFO -> out=0xA5A5, out_valid=1 next cycle, with no pop issued.
  - Pop -> out=0, out_valid=0 next cycle.
- Simultaneous push+pop:
  - At full (num=16), push 0xBEEF with pop -> oldest word read, num stays 16, no overflow.
  - At empty, push+pop -> push accepted, num=1, underflow=1.
- Thresholds, flush and err_clr:
  - ae_thr=3, af_thr=13. num=3 -> almostempty=1; num=4 -> 0; num=13 -> almostfull=1.
  - Flush at num=9 with push=1 -> num=0, empty=1, write ignored.
  - err_clr -> overflow=0, underflow=0.
- Async reset mid-stream:
  - Assert reset between edges at num=7 -> num=0, empty=1, out_valid=0 immediately.
  - First push after deassertion lands at address 0.

Source files
------------

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex: requests, data, thresholds and status.
interface sync_fifo_flex_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
);
  logic              flush;
  logic              push;
  logic [DWIDTH-1:0] in;
  logic              pop;
  logic [AWIDTH:0]   ae_thr;
  logic [AWIDTH:0]   af_thr;
  logic              err_clr;
  logic [DWIDTH-1:0] out;
  logic              out_valid;
  logic              empty;
  logic              full;
  logic              almostempty;
  logic              almostfull;
  logic [AWIDTH:0]   num;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, push, in, pop, ae_thr, af_thr, err_clr,
    input  out, out_valid, empty, full, almostempty, almostfull, num, overflow, underflow
  );

  modport slave (
    input  flush, push, in, pop, ae_thr, af_thr, err_clr,
    output out, out_valid, empty, full, almostempty, almostfull, num, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read, arbitrary depth,
// runtime almost-empty/full thresholds, synchronous flush and sticky error flags.
module sync_fifo_flex #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 16,
  parameter int FWFT   = 0
) (
  input logic             clk,
  input logic             reset,
  sync_fifo_flex_if.slave bus
);
  localparam logic [AWIDTH-1:0] LASTPTR = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH:0]   FULLNUM = (AWIDTH + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [AWIDTH:0]   count;
  logic              is_empty;
  logic              is_full;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf_set;
  logic              unf_set;
  logic              ovf_q;
  logic              unf_q;

  // Flush masks both requests, so a flushing cycle neither moves data nor raises errors.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == FULLNUM);
    wr_ok    = bus.push & (~is_full | bus.pop) & ~bus.flush;
    rd_ok    = bus.pop & ~is_empty & ~bus.flush;
    ovf_set  = bus.push & is_full & ~bus.pop & ~bus.flush;
    unf_set  = bus.pop & is_empty & ~bus.flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= (wptr == LASTPTR) ? '0 : wptr + 1'b1;
      if (rd_ok) rptr <= (rptr == LASTPTR) ? '0 : rptr + 1'b1;
      if (wr_ok & ~rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok & ~wr_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= bus.in;
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (unf_set)          unf_q <= 1'b1;
      else if (bus.err_clr) unf_q <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.out       = is_empty ? '0 : mem[rptr];
    assign bus.out_valid = ~is_empty;
  end else begin : g_std
    logic [DWIDTH-1:0] out_q;
    logic              valid_q;

    // Registered read captures the pre-write word even during write-through at full.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) out_q <= mem[rptr];
      end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
  end

  assign bus.num         = count;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almostempty = (count <= bus.ae_thr);
  assign bus.almostfull  = (count >= bus.af_thr);
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: standard depth-16, standard depth-12 and FWFT instances.
module tb_sync_fifo_flex;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DWIDTH(16), .AWIDTH(4)) busA ();
  sync_fifo_flex_if #(.DWIDTH(16), .AWIDTH(4)) busB ();
  sync_fifo_flex_if #(.DWIDTH(16), .AWIDTH(4)) busC ();

  sync_fifo_flex #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16), .FWFT(0)) dutA (.clk(clk), .reset(reset), .bus(busA));
  sync_fifo_flex #(.DWIDTH(16), .AWIDTH(4), .DEPTH(12), .FWFT(0)) dutB (.clk(clk), .reset(reset), .bus(busB));
  sync_fifo_flex #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16), .FWFT(1)) dutC (.clk(clk), .reset(reset), .bus(busC));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idleAll();
    busA.push = 1'b0; busA.pop = 1'b0; busA.flush = 1'b0; busA.err_clr = 1'b0; busA.in = '0;
    busB.push = 1'b0; busB.pop = 1'b0; busB.flush = 1'b0; busB.err_clr = 1'b0; busB.in = '0;
    busC.push = 1'b0; busC.pop = 1'b0; busC.flush = 1'b0; busC.err_clr = 1'b0; busC.in = '0;
  endtask

  // Drives one cycle of requests on the selected instance, then samples 1 ns after the edge.
  task automatic applyStimulus(input int sel, input logic doPush, input logic [15:0] data,
                               input logic doPop, input logic doFlush, input logic errClr);
    case (sel)
      0: begin busA.push = doPush; busA.in = data; busA.pop = doPop; busA.flush = doFlush; busA.err_clr = errClr; end
      1: begin busB.push = doPush; busB.in = data; busB.pop = doPop; busB.flush = doFlush; busB.err_clr = errClr; end
      default: begin busC.push = doPush; busC.in = data; busC.pop = doPop; busC.flush = doFlush; busC.err_clr = errClr; end
    endcase
    @(posedge clk);
    #1;
    idleAll();
  endtask

  initial begin
    idleAll();
    busA.ae_thr = 5'd3; busA.af_thr = 5'd13;
    busB.ae_thr = 5'd2; busB.af_thr = 5'd12;
    busC.ae_thr = 5'd1; busC.af_thr = 5'd0;

    #12;
    checkOutput("rst_num", busA.num, 0);
    checkOutput("rst_empty", busA.empty, 1);
    checkOutput("rst_full", busA.full, 0);
    checkOutput("rst_ae", busA.almostempty, 1);
    checkOutput("rst_af", busA.almostfull, 0);
    checkOutput("rst_af_thr0", busC.almostfull, 1);
    checkOutput("rst_out", busA.out, 0);
    checkOutput("rst_valid", busA.out_valid, 0);
    checkOutput("rst_ovf", busA.overflow, 0);
    checkOutput("rst_unf", busA.underflow, 0);
    @(negedge clk);
    reset = 1'b0;
    busC.af_thr = 5'd16;

    // Fill A with 1..16, probing the threshold boundaries on the way up.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("fill_num%0d", i), busA.num, i);
      if (i == 3)  checkOutput("ae_at3", busA.almostempty, 1);
      if (i == 4)  checkOutput("ae_at4", busA.almostempty, 0);
      if (i == 12) checkOutput("af_at12", busA.almostfull, 0);
      if (i == 13) checkOutput("af_at13", busA.almostfull, 1);
    end
    checkOutput("full_A", busA.full, 1);

    applyStimulus(0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    checkOutput("wt_out", busA.out, 16'h0001);
    checkOutput("wt_valid", busA.out_valid, 1);
    checkOutput("wt_num", busA.num, 16);
    checkOutput("wt_ovf", busA.overflow, 0);

    applyStimulus(0, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_set", busA.overflow, 1);
    checkOutput("ovf_num", busA.num, 16);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("drain_out%0d", i), busA.out, (i < 15) ? 32'(i + 2) : 32'hBEEF);
      checkOutput($sformatf("drain_valid%0d", i), busA.out_valid, 1);
      checkOutput($sformatf("drain_num%0d", i), busA.num, 15 - i);
    end
    applyStimulus(0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("valid_pulse", busA.out_valid, 0);
    checkOutput("out_hold", busA.out, 16'hBEEF);
    checkOutput("empty_A", busA.empty, 1);

    applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("unf_set", busA.underflow, 1);
    checkOutput("unf_num", busA.num, 0);
    checkOutput("unf_out", busA.out, 16'hBEEF);

    applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_ovf", busA.overflow, 0);
    checkOutput("set_wins_unf", busA.underflow, 1);
    applyStimulus(0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_unf", busA.underflow, 0);

    applyStimulus(0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    checkOutput("emp_pp_num", busA.num, 1);
    checkOutput("emp_pp_unf", busA.underflow, 1);
    checkOutput("emp_pp_valid", busA.out_valid, 0);
    applyStimulus(0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("pre_flush_num", busA.num, 9);
    applyStimulus(0, 1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_num", busA.num, 0);
    checkOutput("flush_empty", busA.empty, 1);
    checkOutput("flush_unf", busA.underflow, 0);
    applyStimulus(0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_out", busA.out, 16'h5555);

    // Depth-12 instance: wrap both pointers past entry 11.
    for (int i = 0; i < 8; i++) applyStimulus(1, 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("b_first_out%0d", i), busB.out, 32'h0200 + i);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1'b1, 16'(16'h0300 + i), 1'b0, 1'b0, 1'b0);
      if (i == 10) checkOutput("b_af_at11", busB.almostfull, 0);
    end
    checkOutput("b_full", busB.full, 1);
    checkOutput("b_num", busB.num, 12);
    checkOutput("b_af", busB.almostfull, 1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("b_wrap_out%0d", i), busB.out, 32'h0300 + i);
      checkOutput($sformatf("b_wrap_num%0d", i), busB.num, 11 - i);
    end
    checkOutput("b_empty", busB.empty, 1);

    // FWFT instance.
    checkOutput("c_idle_out", busC.out, 0);
    checkOutput("c_idle_valid", busC.out_valid, 0);
    applyStimulus(2, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    checkOutput("c_fall_out", busC.out, 16'hA5A5);
    checkOutput("c_fall_valid", busC.out_valid, 1);
    applyStimulus(2, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("c_hold_out", busC.out, 16'hA5A5);
    applyStimulus(2, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0);
    checkOutput("c_second_out", busC.out, 16'hA5A5);
    applyStimulus(2, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("c_pop_out", busC.out, 16'h0102);
    checkOutput("c_pop_num", busC.num, 1);
    applyStimulus(2, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b0);
    checkOutput("c_stream_out", busC.out, 16'h3333);
    checkOutput("c_stream_num", busC.num, 1);
    applyStimulus(2, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("c_last_out", busC.out, 0);
    checkOutput("c_last_valid", busC.out_valid, 0);

    // Asynchronous reset between edges with data in flight.
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 16'(16'h0700 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_num", busA.num, 7);
    checkOutput("pre_rst_valid", busA.out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_num", busA.num, 0);
    checkOutput("arst_empty", busA.empty, 1);
    checkOutput("arst_valid", busA.out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
    checkOutput("arst_addr0", dutA.mem[0], 16'h9999);
    applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("arst_read", busA.out, 16'h9999);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
